// File: rtl/inst_fetch.sv
// Instruction fetch unit: one outstanding read on the instruction memory port, result handed to decode.
// Optional misaligned-fetch trap enabled by defining FETCH_ALIGN_CHECK_EN.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0004,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetch_pc,
  input  logic        fetch_req,
  input  logic        flush,
  output logic        fetch_rdy,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        fetch_fault
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;

  state_t state, state_nxt;
  logic   accept;
  logic   misalign;
  logic   take_fault;
  logic   capture;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misalign = (fetch_pc[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Accepting a fetch only ever happens where the unit would otherwise fall back to IDLE,
  // so the accept path simply overrides the next state chosen below.
  always_comb begin
    fetch_rdy = 1'b0;
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: fetch_rdy = 1'b1;
      REQ: begin
        fetch_rdy = flush & ~mem_req_ready;
        if (flush)              state_nxt = mem_req_ready ? DRAIN : IDLE;
        else if (mem_req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        fetch_rdy = flush & mem_rsp_valid;
        if (flush) begin
          state_nxt = mem_rsp_valid ? IDLE : DRAIN;
        end else if (mem_rsp_valid) begin
          state_nxt = HOLD;
          capture   = 1'b1;
        end
      end
      HOLD: begin
        fetch_rdy = inst_ready | flush;
        if (inst_ready | flush) state_nxt = IDLE;
      end
      DRAIN: begin
        fetch_rdy = mem_rsp_valid;
        if (mem_rsp_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    accept     = fetch_req & fetch_rdy;
    take_fault = accept & misalign;
    if (accept) state_nxt = take_fault ? HOLD : REQ;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      mem_req_valid <= 1'b0;
      mem_addr      <= 32'h0;
      inst_valid    <= 1'b0;
      inst_out      <= NOP_INST;
      inst_pc       <= RESET_PC;
    end else begin
      state         <= state_nxt;
      mem_req_valid <= (state_nxt == REQ);
      inst_valid    <= (state_nxt == HOLD);
      if (accept) begin
        inst_pc <= fetch_pc;
        if (!take_fault) mem_addr <= {fetch_pc[31:2], 2'b00};
      end
      if (take_fault)   inst_out <= NOP_INST;
      else if (capture) inst_out <= mem_rdata;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  // Fault flag lives exactly as long as the faulting pseudo-instruction sits in HOLD.
  always_ff @(posedge clk) begin
    if (!reset) fetch_fault <= 1'b0;
    else        fetch_fault <= (state_nxt == HOLD) & (take_fault | fetch_fault);
  end
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: expected memory requests and decoded instructions are queued
// by the stimulus and retired by independent monitors on each handshake.
module tb_inst_fetch;

  logic        clk;
  logic        reset;
  logic [31:0] fetch_pc;
  logic        fetch_req;
  logic        flush;
  logic        fetch_rdy;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        fetch_fault;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  exp_t        iq[$];
  logic [31:0] mq[$];
  int          checks;
  int          errors;

  inst_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_pc      (fetch_pc),
    .fetch_req     (fetch_req),
    .flush         (flush),
    .fetch_rdy     (fetch_rdy),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_out      (inst_out),
    .inst_pc       (inst_pc),
    .fetch_fault   (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Memory request monitor
  always @(negedge clk) begin
    if (reset && mem_req_valid && mem_req_ready) begin
      if (mq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mem_unexpected: got addr 0x%08h expected no request", mem_addr);
      end else begin
        chk("mem_addr_sb", mem_addr, mq.pop_front());
      end
    end
  end

  // Decode handshake monitor
  always @(negedge clk) begin
    exp_t e;
    if (reset && inst_valid && inst_ready) begin
      if (iq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL inst_unexpected: got inst 0x%08h pc 0x%08h expected none", inst_out, inst_pc);
      end else begin
        e = iq.pop_front();
        chk("inst_out_sb", inst_out, e.inst);
        chk("inst_pc_sb", inst_pc, e.pc);
        chk("fault_sb", {31'b0, fetch_fault}, {31'b0, e.fault});
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0; fetch_pc = '0; fetch_req = 1'b0; flush = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0; inst_ready = 1'b0;

    // Reset
    cyc(); cyc();
    @(negedge clk);
    chk("rst_inst_pc", inst_pc, 32'h4);
    chk("rst_inst_out", inst_out, 32'h13);
    chk("rst_mem_vld", {31'b0, mem_req_valid}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_inst_vld", {31'b0, inst_valid}, 32'h0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'h0);
    chk("rst_rdy", {31'b0, fetch_rdy}, 32'h1);
    cyc(); reset = 1'b1;
    cyc();

    // Basic fetch, held three cycles
    fetch_req = 1'b1; fetch_pc = 32'h100; mem_req_ready = 1'b1;
    mq.push_back(32'h100);
    iq.push_back({32'h00500093, 32'h100, 1'b0});
    @(negedge clk); chk("rdy_idle", {31'b0, fetch_rdy}, 32'h1);
    cyc(); fetch_req = 1'b0;
    @(negedge clk);
    chk("req_vld", {31'b0, mem_req_valid}, 32'h1);
    chk("req_addr", mem_addr, 32'h100);
    cyc(); mem_rsp_valid = 1'b1; mem_rdata = 32'h00500093;
    @(negedge clk); chk("no_early_vld", {31'b0, inst_valid}, 32'h0);
    cyc(); mem_rsp_valid = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_vld", {31'b0, inst_valid}, 32'h1);
      chk("hold_inst", inst_out, 32'h00500093);
      chk("hold_pc", inst_pc, 32'h100);
      cyc();
    end

    // Back-to-back consume and fetch
    inst_ready = 1'b1; fetch_req = 1'b1; fetch_pc = 32'h104;
    mq.push_back(32'h104);
    iq.push_back({32'h00A00113, 32'h104, 1'b0});
    @(negedge clk); chk("rdy_hold_ready", {31'b0, fetch_rdy}, 32'h1);
    cyc(); inst_ready = 1'b0; fetch_req = 1'b0;
    @(negedge clk);
    chk("b2b_no_overlap", {31'b0, inst_valid}, 32'h0);
    chk("b2b_req_vld", {31'b0, mem_req_valid}, 32'h1);
    chk("b2b_addr", mem_addr, 32'h104);
    cyc(); mem_rsp_valid = 1'b1; mem_rdata = 32'h00A00113;
    cyc(); mem_rsp_valid = 1'b0; inst_ready = 1'b1;
    @(negedge clk); chk("b2b_vld", {31'b0, inst_valid}, 32'h1);
    cyc(); inst_ready = 1'b0;

    // Backpressure with flush in REQ, then flush in WAIT with late response
    inst_ready = 1'b1; mem_req_ready = 1'b0; fetch_req = 1'b1; fetch_pc = 32'h108;
    cyc(); fetch_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("bp_vld", {31'b0, mem_req_valid}, 32'h1);
      chk("bp_addr", mem_addr, 32'h108);
      cyc();
    end
    flush = 1'b1;
    @(negedge clk); chk("rdy_req_flush", {31'b0, fetch_rdy}, 32'h1);
    cyc(); flush = 1'b0;
    @(negedge clk); chk("withdrawn", {31'b0, mem_req_valid}, 32'h0);
    cyc(); mem_req_ready = 1'b1; fetch_req = 1'b1; fetch_pc = 32'h10C;
    mq.push_back(32'h10C);
    cyc(); fetch_req = 1'b0;
    cyc(); flush = 1'b1;
    @(negedge clk); chk("rdy_wait_flush", {31'b0, fetch_rdy}, 32'h0);
    cyc(); flush = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("rdy_drain_rsp", {31'b0, fetch_rdy}, 32'h1);
    chk("drain_vld", {31'b0, inst_valid}, 32'h0);
    cyc(); mem_rsp_valid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    chk("drop_vld", {31'b0, inst_valid}, 32'h0);
    chk("idle_after_drain", {31'b0, fetch_rdy}, 32'h1);
    cyc(); inst_ready = 1'b0;

    // Redirect while holding an instruction
    fetch_req = 1'b1; fetch_pc = 32'h110;
    mq.push_back(32'h110);
    cyc(); fetch_req = 1'b0;
    cyc(); mem_rsp_valid = 1'b1; mem_rdata = 32'h11111111;
    cyc(); mem_rsp_valid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    chk("redir_old_vld", {31'b0, inst_valid}, 32'h1);
    chk("redir_old_inst", inst_out, 32'h11111111);
    cyc(); flush = 1'b1; fetch_req = 1'b1; fetch_pc = 32'h200;
    mq.push_back(32'h200);
    iq.push_back({32'h22222222, 32'h200, 1'b0});
    @(negedge clk); chk("rdy_redirect", {31'b0, fetch_rdy}, 32'h1);
    cyc(); flush = 1'b0; fetch_req = 1'b0;
    @(negedge clk);
    chk("redir_dropped", {31'b0, inst_valid}, 32'h0);
    chk("redir_addr", mem_addr, 32'h200);
    cyc(); mem_rsp_valid = 1'b1; mem_rdata = 32'h22222222;
    cyc(); mem_rsp_valid = 1'b0; inst_ready = 1'b1;
    @(negedge clk); chk("redir_vld", {31'b0, inst_valid}, 32'h1);
    cyc(); inst_ready = 1'b0;

    // Misaligned fetch
    fetch_req = 1'b1; fetch_pc = 32'h102;
`ifdef FETCH_ALIGN_CHECK_EN
    iq.push_back({32'h13, 32'h102, 1'b1});
    cyc(); fetch_req = 1'b0;
    @(negedge clk);
    chk("mis_no_req", {31'b0, mem_req_valid}, 32'h0);
    chk("mis_vld", {31'b0, inst_valid}, 32'h1);
    chk("mis_fault", {31'b0, fetch_fault}, 32'h1);
    chk("mis_inst", inst_out, 32'h13);
    cyc(); inst_ready = 1'b1;
    cyc(); inst_ready = 1'b0;
    @(negedge clk); chk("mis_fault_clr", {31'b0, fetch_fault}, 32'h0);
    cyc();
`else
    mq.push_back(32'h100);
    iq.push_back({32'h33333333, 32'h102, 1'b0});
    cyc(); fetch_req = 1'b0;
    @(negedge clk);
    chk("mis_addr", mem_addr, 32'h100);
    chk("mis_req", {31'b0, mem_req_valid}, 32'h1);
    cyc(); mem_rsp_valid = 1'b1; mem_rdata = 32'h33333333;
    cyc(); mem_rsp_valid = 1'b0; inst_ready = 1'b1;
    @(negedge clk); chk("mis_fault_zero", {31'b0, fetch_fault}, 32'h0);
    cyc(); inst_ready = 1'b0;
`endif

    // Reset mid-transaction; stale response afterwards is ignored
    mem_req_ready = 1'b0; fetch_req = 1'b1; fetch_pc = 32'h120;
    cyc(); fetch_req = 1'b0; reset = 1'b0;
    cyc(); reset = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 32'h44444444;
    @(negedge clk);
    chk("rst_mid_vld", {31'b0, mem_req_valid}, 32'h0);
    chk("rst_mid_pc", inst_pc, 32'h4);
    cyc(); mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("stale_rsp_vld", {31'b0, inst_valid}, 32'h0);
    chk("stale_rsp_inst", inst_out, 32'h13);
    cyc(); cyc();

    chk("iq_empty", iq.size(), 32'h0);
    chk("mq_empty", mq.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
